// File: rtl/ui_pkg.sv
// Shared types and constants for the front-panel input conditioning logic.
package ui_pkg;

    typedef enum logic [1:0] {
        IDLE            = 2'd0,
        PRESS_PENDING   = 2'd1,
        PRESSED         = 2'd2,
        RELEASE_PENDING = 2'd3
    } chanState_e;

    localparam int DEBOUNCE_10MS_AT_50MHZ = 500000;
    localparam int HOLD_1S_AT_50MHZ       = 50000000;

    // Channel assignment of the music box front panel.
    localparam int MUSIC_KEY0     = 0;
    localparam int MUSIC_KEY1     = 1;
    localparam int MUSIC_KEY2     = 2;
    localparam int MUSIC_KEY3     = 3;
    localparam int MUSIC_KEY4     = 4;
    localparam int MUSIC_KEY5     = 5;
    localparam int PLAY_SONG0     = 6;
    localparam int PLAY_SONG1     = 7;
    localparam int MAKE_RECORDING = 8;
    localparam int PLAY_RECORDING = 9;

endpackage

// File: rtl/ui_channel_debounce.sv
// One input channel: synchroniser, debounce FSM, press/release pulses and
// single-shot long-press detection. All outputs are registered.
module ui_channel_debounce
    import ui_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_AT_50MHZ,
    parameter int HOLD_CYCLES     = HOLD_1S_AT_50MHZ,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clock_50Mhz,
    input  logic reset_n,
    input  logic rawIn,
    output logic debLevel,
    output logic pressPulse,
    output logic releasePulse,
    output logic holdPulse
);

    localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HCW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HCW-1:0] HOLD_MAX = HCW'(HOLD_CYCLES);
    localparam bit HOLD_EN  = (HOLD_CYCLES != 0);
    localparam logic IDLE_RAW = ACTIVE_LOW;

    logic [SYNC_STAGES-1:0] syncReg;
    logic                   sample;
    chanState_e             state, nextState;
    logic [DCW-1:0]         debCnt, nextCnt;
    logic [HCW-1:0]         holdCnt;

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            syncReg <= {SYNC_STAGES{IDLE_RAW}};
        end else begin
            syncReg <= {syncReg[SYNC_STAGES-2:0], rawIn};
        end
    end

    // Normalise polarity so that 1 always means pressed from here on.
    assign sample = syncReg[SYNC_STAGES-1] ^ IDLE_RAW;

    always_comb begin
        nextState = state;
        nextCnt   = debCnt;
        unique case (state)
            IDLE: begin
                if (sample) begin
                    nextState = PRESS_PENDING;
                    nextCnt   = DCW'(1);
                end
            end
            PRESS_PENDING: begin
                if (!sample) begin
                    nextState = IDLE;
                    nextCnt   = '0;
                end else if (debCnt == DEB_LAST) begin
                    nextState = PRESSED;
                    nextCnt   = '0;
                end else begin
                    nextCnt = debCnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!sample) begin
                    nextState = RELEASE_PENDING;
                    nextCnt   = DCW'(1);
                end
            end
            RELEASE_PENDING: begin
                if (sample) begin
                    nextState = PRESSED;
                    nextCnt   = '0;
                end else if (debCnt == DEB_LAST) begin
                    nextState = IDLE;
                    nextCnt   = '0;
                end else begin
                    nextCnt = debCnt + 1'b1;
                end
            end
            default: begin
                nextState = IDLE;
                nextCnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            debCnt       <= '0;
            debLevel     <= 1'b0;
            pressPulse   <= 1'b0;
            releasePulse <= 1'b0;
        end else begin
            state        <= nextState;
            debCnt       <= nextCnt;
            debLevel     <= (nextState == PRESSED) || (nextState == RELEASE_PENDING);
            pressPulse   <= (state == PRESS_PENDING) && (nextState == PRESSED);
            releasePulse <= (state == RELEASE_PENDING) && (nextState == IDLE);
        end
    end

    // Saturating hold count; the pulse fires as the count steps onto HOLD_MAX.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            holdCnt   <= '0;
            holdPulse <= 1'b0;
        end else begin
            holdPulse <= HOLD_EN && debLevel && (holdCnt == HOLD_MAX - 1'b1);
            if (!debLevel) begin
                holdCnt <= '0;
            end else if (holdCnt != HOLD_MAX) begin
                holdCnt <= holdCnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ui_input_conditioner.sv
// Multi-channel front-panel input conditioner: per-channel debounce plus a
// registered lowest-index priority encoder over the debounced levels.
module ui_input_conditioner
    import ui_pkg::*;
#(
    parameter int NUM_CHANNELS    = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_AT_50MHZ,
    parameter int HOLD_CYCLES     = HOLD_1S_AT_50MHZ,
    parameter bit ACTIVE_LOW      = 1'b1,
    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clock_50Mhz,
    input  logic                    reset_n,
    input  logic [NUM_CHANNELS-1:0] inputWire,
    output logic [NUM_CHANNELS-1:0] outputLevel,
    output logic [NUM_CHANNELS-1:0] outputPress,
    output logic [NUM_CHANNELS-1:0] outputRelease,
    output logic [NUM_CHANNELS-1:0] outputHold,
    output logic                    anyPressed,
    output logic [IDX_W-1:0]        lowestPressedIndex
);

    logic [IDX_W-1:0] lowestIdx;

    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : gChannel
        ui_channel_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) uChannel (
            .clock_50Mhz (clock_50Mhz),
            .reset_n     (reset_n),
            .rawIn       (inputWire[ch]),
            .debLevel    (outputLevel[ch]),
            .pressPulse  (outputPress[ch]),
            .releasePulse(outputRelease[ch]),
            .holdPulse   (outputHold[ch])
        );
    end

    // Scan downwards so the lowest pressed channel is the last to win.
    always_comb begin
        lowestIdx = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (outputLevel[i]) begin
                lowestIdx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            anyPressed         <= 1'b0;
            lowestPressedIndex <= '0;
        end else begin
            anyPressed         <= |outputLevel;
            lowestPressedIndex <= lowestIdx;
        end
    end

endmodule

// File: tb/tb_ui_input_conditioner.sv
// Directed bench for ui_input_conditioner with short debounce/hold timing.
module tb_ui_input_conditioner;

    localparam int N     = 4;
    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     inW;
    logic [N-1:0]     level, press, rel, hold;
    logic             anyP;
    logic [IDX_W-1:0] lowIdx;

    int checks = 0;
    int fails  = 0;
    int pCnt[N];
    int rCnt[N];
    int hCnt[N];

    always #5 clk = ~clk;

    ui_input_conditioner #(
        .NUM_CHANNELS   (N),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (10),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clock_50Mhz       (clk),
        .reset_n           (rst_n),
        .inputWire         (inW),
        .outputLevel       (level),
        .outputPress       (press),
        .outputRelease     (rel),
        .outputHold        (hold),
        .anyPressed        (anyP),
        .lowestPressedIndex(lowIdx)
    );

    // Advance one active edge, settle, and tally any pulses seen.
    task automatic step();
        @(posedge clk);
        #2;
        for (int c = 0; c < N; c++) begin
            if (press[c] === 1'b1) pCnt[c]++;
            if (rel[c]   === 1'b1) rCnt[c]++;
            if (hold[c]  === 1'b1) hCnt[c]++;
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clearCounts();
        for (int c = 0; c < N; c++) begin
            pCnt[c] = 0;
            rCnt[c] = 0;
            hCnt[c] = 0;
        end
    endtask

    task automatic test_reset();
        logic stayedZero;
        rst_n = 1'b1;
        inW   = '1;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({level, press, rel, hold} !== '0) begin
            fails++;
            $display("FAIL reset_pulses: got %h expected 0", {level, press, rel, hold});
        end
        checks++;
        if ({anyP, lowIdx} !== '0) begin
            fails++;
            $display("FAIL reset_prio: got any=%b idx=%0d expected any=0 idx=0", anyP, lowIdx);
        end
        steps(2);
        rst_n = 1'b1;
        clearCounts();
        stayedZero = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step();
            if ({level, press, rel, hold, anyP, lowIdx} !== '0) stayedZero = 1'b0;
        end
        checks++;
        if (stayedZero !== 1'b1) begin
            fails++;
            $display("FAIL reset_idle50: got nonzero output expected all 0");
        end
    endtask

    task automatic test_clean_press();
        clearCounts();
        inW[0] = 1'b0;
        steps(5);
        checks++;
        if (level[0] !== 1'b0) begin
            fails++;
            $display("FAIL clean_level_e5: got %b expected 0", level[0]);
        end
        step();
        checks++;
        if (level[0] !== 1'b1 || press[0] !== 1'b1) begin
            fails++;
            $display("FAIL clean_press_e6: got level=%b press=%b expected 1 1", level[0], press[0]);
        end
        step();
        checks++;
        if (press[0] !== 1'b0 || anyP !== 1'b1 || lowIdx !== 2'd0) begin
            fails++;
            $display("FAIL clean_after: got press=%b any=%b idx=%0d expected 0 1 0", press[0], anyP, lowIdx);
        end
        inW[0] = 1'b1;
        steps(5);
        checks++;
        if (level[0] !== 1'b1 || rel[0] !== 1'b0) begin
            fails++;
            $display("FAIL clean_rel_e5: got level=%b rel=%b expected 1 0", level[0], rel[0]);
        end
        step();
        checks++;
        if (level[0] !== 1'b0 || rel[0] !== 1'b1) begin
            fails++;
            $display("FAIL clean_rel_e6: got level=%b rel=%b expected 0 1", level[0], rel[0]);
        end
        steps(2);
        checks++;
        if (pCnt[0] != 1 || rCnt[0] != 1 || hCnt[0] != 0 || anyP !== 1'b0) begin
            fails++;
            $display("FAIL clean_counts: got p=%0d r=%0d h=%0d any=%b expected 1 1 0 0", pCnt[0], rCnt[0], hCnt[0], anyP);
        end
        checks++;
        if (pCnt[1] + pCnt[2] + pCnt[3] + rCnt[1] + rCnt[2] + rCnt[3] != 0) begin
            fails++;
            $display("FAIL clean_others: got %0d stray pulses expected 0",
                     pCnt[1] + pCnt[2] + pCnt[3] + rCnt[1] + rCnt[2] + rCnt[3]);
        end
    endtask

    task automatic test_bounce();
        logic everHigh;
        clearCounts();
        everHigh = 1'b0;
        for (int k = 0; k < 5; k++) begin
            inW[2] = 1'b0;
            step(); if (level[2] !== 1'b0) everHigh = 1'b1;
            step(); if (level[2] !== 1'b0) everHigh = 1'b1;
            inW[2] = 1'b1;
            step(); if (level[2] !== 1'b0) everHigh = 1'b1;
            step(); if (level[2] !== 1'b0) everHigh = 1'b1;
        end
        checks++;
        if (everHigh !== 1'b0 || pCnt[2] != 0 || rCnt[2] != 0) begin
            fails++;
            $display("FAIL bounce_reject: got high=%b p=%0d r=%0d expected 0 0 0", everHigh, pCnt[2], rCnt[2]);
        end
        inW[2] = 1'b0;
        steps(5);
        checks++;
        if (level[2] !== 1'b0) begin
            fails++;
            $display("FAIL bounce_level_e5: got %b expected 0", level[2]);
        end
        step();
        checks++;
        if (press[2] !== 1'b1 || level[2] !== 1'b1) begin
            fails++;
            $display("FAIL bounce_press_e6: got press=%b level=%b expected 1 1", press[2], level[2]);
        end
        steps(4);
        checks++;
        if (pCnt[2] != 1) begin
            fails++;
            $display("FAIL bounce_single: got %0d presses expected 1", pCnt[2]);
        end
        inW[2] = 1'b1;
        steps(8);
        checks++;
        if (rCnt[2] != 1 || level[2] !== 1'b0) begin
            fails++;
            $display("FAIL bounce_release: got r=%0d level=%b expected 1 0", rCnt[2], level[2]);
        end
    endtask

    task automatic test_long_press();
        clearCounts();
        inW[1] = 1'b0;
        steps(6);
        checks++;
        if (press[1] !== 1'b1) begin
            fails++;
            $display("FAIL hold_press: got %b expected 1", press[1]);
        end
        steps(9);
        checks++;
        if (hold[1] !== 1'b0 || hCnt[1] != 0) begin
            fails++;
            $display("FAIL hold_early: got hold=%b cnt=%0d expected 0 0", hold[1], hCnt[1]);
        end
        step();
        checks++;
        if (hold[1] !== 1'b1) begin
            fails++;
            $display("FAIL hold_pulse: got %b expected 1", hold[1]);
        end
        steps(24);
        checks++;
        if (hCnt[1] != 1) begin
            fails++;
            $display("FAIL hold_once: got %0d expected 1", hCnt[1]);
        end
        inW[1] = 1'b1;
        steps(8);
        inW[1] = 1'b0;
        steps(6);
        checks++;
        if (press[1] !== 1'b1) begin
            fails++;
            $display("FAIL hold_repress: got %b expected 1", press[1]);
        end
        steps(10);
        checks++;
        if (hold[1] !== 1'b1 || hCnt[1] != 2) begin
            fails++;
            $display("FAIL hold_second: got hold=%b cnt=%0d expected 1 2", hold[1], hCnt[1]);
        end
        inW[1] = 1'b1;
        steps(8);
        checks++;
        if (rCnt[1] != 2 || hCnt[0] + hCnt[2] + hCnt[3] != 0) begin
            fails++;
            $display("FAIL hold_tail: got r=%0d stray=%0d expected 2 0", rCnt[1], hCnt[0] + hCnt[2] + hCnt[3]);
        end
    endtask

    task automatic test_simultaneous();
        clearCounts();
        inW[1] = 1'b0;
        inW[3] = 1'b0;
        steps(6);
        checks++;
        if (press !== 4'b1010) begin
            fails++;
            $display("FAIL sim_press: got %b expected 1010", press);
        end
        step();
        checks++;
        if (lowIdx !== 2'd1 || anyP !== 1'b1) begin
            fails++;
            $display("FAIL sim_prio: got idx=%0d any=%b expected 1 1", lowIdx, anyP);
        end
        inW[1] = 1'b1;
        steps(6);
        checks++;
        if (level !== 4'b1000 || rel !== 4'b0010) begin
            fails++;
            $display("FAIL sim_rel1: got level=%b rel=%b expected 1000 0010", level, rel);
        end
        step();
        checks++;
        if (lowIdx !== 2'd3 || anyP !== 1'b1) begin
            fails++;
            $display("FAIL sim_prio3: got idx=%0d any=%b expected 3 1", lowIdx, anyP);
        end
        inW[3] = 1'b1;
        steps(7);
        checks++;
        if (lowIdx !== 2'd0 || anyP !== 1'b0) begin
            fails++;
            $display("FAIL sim_none: got idx=%0d any=%b expected 0 0", lowIdx, anyP);
        end
    endtask

    task automatic test_reset_mid_hold();
        clearCounts();
        inW[0] = 1'b0;
        steps(6);
        checks++;
        if (press[0] !== 1'b1) begin
            fails++;
            $display("FAIL rmh_press: got %b expected 1", press[0]);
        end
        steps(5);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({level, press, rel, hold, anyP, lowIdx} !== '0) begin
            fails++;
            $display("FAIL rmh_async: got %h expected 0", {level, press, rel, hold, anyP, lowIdx});
        end
        steps(2);
        rst_n = 1'b1;
        clearCounts();
        steps(5);
        checks++;
        if (level[0] !== 1'b0 || rCnt[0] != 0) begin
            fails++;
            $display("FAIL rmh_e5: got level=%b r=%0d expected 0 0", level[0], rCnt[0]);
        end
        step();
        checks++;
        if (press[0] !== 1'b1 || rCnt[0] != 0 || hCnt[0] != 0) begin
            fails++;
            $display("FAIL rmh_repress: got press=%b r=%0d h=%0d expected 1 0 0", press[0], rCnt[0], hCnt[0]);
        end
        inW[0] = 1'b1;
        steps(8);
    endtask

    initial begin
        clearCounts();
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_simultaneous();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ui_input_conditioner.md
Name: ui_input_conditioner

Overview:
Parametrised multi-channel conditioner for raw front-panel GPIO inputs (music keys, song, record and playback buttons). It replaces per-input smoother instances with one block.
- Per channel: metastability synchroniser, debounce, press/release edge pulses, single-shot long-press detect.
- Across channels: pressed-key priority encoding.
- Sits between top-level GPIO pins and the state controller / music keys controller.

Parameters:
NUM_CHANNELS, 10, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flop depth (>=2)
DEBOUNCE_CYCLES, 500000, consecutive stable synchronised cycles needed to accept a level change (10 ms at 50 MHz; >=2)
HOLD_CYCLES, 50000000, cycles of accepted press before long-press pulse (1 s); 0 disables hold detection
ACTIVE_LOW, 1, 1: raw input low means pressed (LVTTL pull-up switches); 0: high means pressed

Ports:
clock_50Mhz  input  1  system clock, sole clock domain
reset_n  input  1  asynchronous, active-low reset
inputWire  input  NUM_CHANNELS  raw asynchronous switch inputs
outputLevel  output  NUM_CHANNELS  debounced pressed state, 1 = pressed regardless of ACTIVE_LOW
outputPress  output  NUM_CHANNELS  one-cycle pulse on accepted press
outputRelease  output  NUM_CHANNELS  one-cycle pulse on accepted release
outputHold  output  NUM_CHANNELS  one-cycle pulse when press held HOLD_CYCLES
anyPressed  output  1  OR of outputLevel
lowestPressedIndex  output  IDX_W=max(1,$clog2(NUM_CHANNELS))  index of lowest-numbered pressed channel; 0 when none pressed

Behaviour:
- Clock and reset: one clock (clock_50Mhz); reset_n asynchronous, active-low. While reset_n=0, all outputs are 0 immediately.
- Reset state: synchroniser flops hold the inactive raw level (1 if ACTIVE_LOW, else 0); channel FSMs in IDLE; all counters 0.
- Polarity: raw sample inverted when ACTIVE_LOW=1, so internal "pressed"=1.
- Per-channel FSM states: IDLE, PRESS_PENDING, PRESSED, RELEASE_PENDING.
  - IDLE: sync sample pressed -> PRESS_PENDING, debounce counter=1.
  - PRESS_PENDING: sample pressed -> counter+1; counter reaching DEBOUNCE_CYCLES-1 while pressed -> PRESSED. Sample released -> IDLE with counter cleared (bounce restarts the count).
  - PRESSED: sample released -> RELEASE_PENDING, counter=1.
  - RELEASE_PENDING: symmetric to PRESS_PENDING; completes to IDLE, or returns to PRESSED on bounce.
- Latency: if the raw value changes before edge 1 and stays stable, outputLevel changes after edge SYNC_STAGES+DEBOUNCE_CYCLES. outputPress/outputRelease are high for exactly the cycle outputLevel first shows the new value.
- Hold counter:
  - Clears to 0 when outputLevel=0; increments each cycle outputLevel=1; saturates at HOLD_CYCLES.
  - outputHold pulses once, in the cycle the count reaches HOLD_CYCLES (HOLD_CYCLES cycles after the outputPress cycle).
  - No repeat until release and re-press; never asserts when HOLD_CYCLES=0.
- Counter widths: $clog2(DEBOUNCE_CYCLES+1) and $clog2(HOLD_CYCLES+1); no wrap-around is possible.
- Priority outputs:
  - anyPressed and lowestPressedIndex are registered from the same-cycle outputLevel, so they lag outputLevel by 1 cycle.
  - Simultaneous presses: lowest index wins.
- Channels are fully independent; simultaneous events on different channels all pulse in the same cycle.
- Reset mid-operation:
  - Pending or accepted presses are discarded.
  - After reset_n deasserts with an input still held, a full sync+debounce is required; then outputPress pulses normally.
  - A release pulse is never generated for a press lost in reset.
- All outputs are driven from flops; there are no combinational paths from inputWire.

Decomposition:
- Shared package ui_pkg:
  - channel state enum (IDLE, PRESS_PENDING, PRESSED, RELEASE_PENDING);
  - default timing constants DEBOUNCE_10MS_AT_50MHZ=500000 and HOLD_1S_AT_50MHZ=50000000;
  - standard channel-index constants for the music box (MUSIC_KEY0..5, PLAY_SONG0/1, MAKE_RECORDING, PLAY_RECORDING).
- One sub-module, ui_channel_debounce: synchroniser, FSM, debounce and hold counters and pulses for one channel. It is instantiated NUM_CHANNELS times via generate; the top adds only the priority encoder.

Test Plan:
(bench parameters: NUM_CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, ACTIVE_LOW=1)
- Reset: inputs all 1, reset_n=0 then 1 -> all outputs 0, lowestPressedIndex=0, and they stay 0 for 50 cycles.
- Clean press: inputWire[0] 1->0 before edge 1 -> outputLevel[0]=1 and outputPress[0] pulse after edge 6. Return to 1 -> outputRelease[0] pulse 6 edges later; no other pulses.
- Bounce rejection: inputWire[2] toggles every 2 cycles for 20 cycles -> outputLevel[2] stays 0 with no pulses. Then held 0 -> exactly one outputPress[2], 6 edges after the final transition.
- Long press: inputWire[1] held 0 for 40 cycles -> exactly one outputHold[1], 10 cycles after outputPress[1]. Release and re-press -> a second outputHold[1] after another 10 cycles.
- Simultaneous: channels 1 and 3 pressed on the same edge -> outputPress[1] and outputPress[3] in the same cycle; next cycle lowestPressedIndex=1, anyPressed=1. Release channel 1 -> index becomes 3; release channel 3 -> anyPressed=0, index 0.
- Reset mid-hold: reset_n=0 at 5 cycles after outputPress[0] -> outputs 0 asynchronously. Deassert with inputWire[0] still 0 -> outputPress[0] after edge 6, no outputRelease[0] in between.
